// File: rtl/mult_div_ctrl.sv
// Iterative 32-bit unsigned multiply/divide sequencer.
// One shift-add or shift-subtract step per cycle on an external shared adder.
module mult_div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_ao,
   input  logic [31:0] add_result,
   input  logic        add_carry
);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] opnd;
   logic [31:0] opnd_nx;
   logic [31:0] hi_nx;
   logic [31:0] lo_nx;
   logic [4:0]  cnt;
   logic [4:0]  cnt_nx;
   logic        dbz_nx;
   logic [31:0] r_sh;
   logic        qbit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hi          <= '0;
         lo          <= '0;
         opnd        <= '0;
         cnt         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nx;
         hi          <= hi_nx;
         lo          <= lo_nx;
         opnd        <= opnd_nx;
         cnt         <= cnt_nx;
         div_by_zero <= dbz_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hi_nx    = hi;
      lo_nx    = lo;
      opnd_nx  = opnd;
      cnt_nx   = cnt;
      dbz_nx   = div_by_zero;
      add_a    = '0;
      add_b    = '0;
      add_ao   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      r_sh     = {hi[30:0], lo[31]};
      qbit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               dbz_nx = 1'b0;
               cnt_nx = '0;
               hi_nx  = '0;
               if (!op) begin
                  lo_nx    = rt_val;
                  opnd_nx  = rs_val;
                  state_nx = MUL;
               end else if (rt_val == 32'd0) begin
                  // divide-by-zero completes without iterating
                  hi_nx    = rs_val;
                  lo_nx    = '1;
                  opnd_nx  = rt_val;
                  dbz_nx   = 1'b1;
                  state_nx = DONE;
               end else begin
                  lo_nx    = rs_val;
                  opnd_nx  = rt_val;
                  state_nx = DIV;
               end
            end
         end
         MUL: begin
            busy   = 1'b1;
            add_a  = hi;
            add_b  = lo[0] ? opnd : 32'd0;
            hi_nx  = {add_carry, add_result[31:1]};
            lo_nx  = {add_result[0], lo[31:1]};
            cnt_nx = cnt + 5'd1;
            if (cnt == 5'd31)
               state_nx = DONE;
         end
         DIV: begin
            busy   = 1'b1;
            add_a  = r_sh;
            add_b  = opnd;
            add_ao = 1'b1;
            // shifted-out msb means remainder already exceeds divisor
            qbit   = hi[31] | add_carry;
            hi_nx  = qbit ? add_result : r_sh;
            lo_nx  = {lo[30:0], qbit};
            cnt_nx = cnt + 5'd1;
            if (cnt == 5'd31)
               state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl with a behavioural shared adder.
module tb_mult_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_ao;
   logic [31:0] add_result;
   logic        add_carry;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   int   nvec;
   int   nerr;
   int   cyc;
   int   bcnt;

   mult_div_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_ao      (add_ao),
      .add_result  (add_result),
      .add_carry   (add_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      {add_carry, add_result} = {1'b0, add_a}
                              + {1'b0, (add_ao ? ~add_b : add_b)}
                              + {32'd0, add_ao};
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      nvec++;
      if (obs !== expv) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // monitor: compares every done pulse against the scoreboard head
   initial begin
      exp_t e;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bcnt = 0;
         end else if (done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               last = e;
               chk("hi", {32'd0, hi}, {32'd0, e.hi});
               chk("lo", {32'd0, lo}, {32'd0, e.lo});
               chk("dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               chk("busy_cycles", 64'(bcnt), 64'(e.lat == 0 ? 0 : 32));
               chk("add_done", {32'd0, add_a | add_b | {31'd0, add_ao}},
                   64'd0);
               chk("busy_in_done", {63'd0, busy}, 64'd0);
            end
            bcnt = 0;
         end else if (busy) begin
            bcnt++;
         end
      end
   end

   function automatic exp_t model(input logic o, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t  e;
      logic [63:0] p;
      e.dbz = 1'b0;
      e.lat = 32;
      e.acc = 0;
      if (!o) begin
         p    = {32'd0, a} * {32'd0, b};
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'd0) begin
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
         e.dbz = 1'b1;
         e.lat = 0;
      end else begin
         e.hi = a % b;
         e.lo = a / b;
      end
      return e;
   endfunction

   task automatic issue(input logic o, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      e     = model(o, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         chk("timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic run(input logic o, input logic [31:0] a,
                      input logic [31:0] b);
      issue(o, a, b);
      drain();
   endtask

   initial begin
      nvec   = 0;
      nerr   = 0;
      cyc    = 0;
      rst    = 1'b1;
      start  = 1'b0;
      op     = 1'b0;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("add_idle", {32'd0, add_a | add_b | {31'd0, add_ao}}, 64'd0);

      run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(1'b1, 32'd100, 32'd7);
      run(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
      run(1'b1, 32'h8000_0000, 32'd0);
      run(1'b0, 32'd2, 32'd3);

      // start re-pulsed mid-multiply must be ignored
      issue(1'b0, 32'h1234_5678, 32'd3);
      repeat (4) @(negedge clk);
      start  = 1'b1;
      op     = 1'b1;
      rs_val = 32'hDEAD_BEEF;
      rt_val = 32'd0;
      @(negedge clk);
      start = 1'b0;
      drain();

      // start during DONE is ignored and results hold afterwards
      issue(1'b1, 32'd1000, 32'd33);
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      start  = 1'b1;
      op     = 1'b0;
      rs_val = 32'd5;
      rt_val = 32'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ign_done_busy", {63'd0, busy}, 64'd0);
      chk("hold_hi", {32'd0, hi}, 64'd10);
      chk("hold_lo", {32'd0, lo}, 64'd30);
      chk("hold_vs_last", {hi, lo}, {last.hi, last.lo});

      // reset at iteration 10 of a divide, start coincident with rst
      issue(1'b1, 32'hCAFE_0000, 32'd9);
      repeat (9) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      op    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      exp_q.delete();
      chk("mid_rst_hilo", {hi, lo}, 64'd0);
      chk("mid_rst_busy", {62'd0, busy, done}, 64'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_rst_idle", {63'd0, busy}, 64'd0);
      run(1'b0, 32'd6, 32'd7);

      for (int k = 0; k < 12; k++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = (k % 3 == 0) ? $urandom_range(1, 255) : $urandom;
         if (k == 7) b = 32'd0;
         run(k[0], a, b);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  operation request, sampled on rising edge of clk.
REQ-004 SHALL have port: op  input  1  0 = MULTU, 1 = DIVU (unsigned).
REQ-005 SHALL have port: rs_val  input  32  multiplicand or dividend.
REQ-006 SHALL have port: rt_val  input  32  multiplier or divisor.
REQ-007 SHALL have port: busy  output  1  high while an operation iterates.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: hi  output  32  product high word or remainder.
REQ-010 SHALL have port: lo  output  32  product low word or quotient.
REQ-011 SHALL have port: div_by_zero  output  1  high with done when DIVU had rt_val = 0.
REQ-012 SHALL have port: add_a  output  32  operand A to the shared 32-bit adder/subtractor.
REQ-013 SHALL have port: add_b  output  32  operand B to the adder.
REQ-014 SHALL have port: add_ao  output  1  adder mode, 0 = A+B, 1 = A+~B+1.
REQ-015 SHALL have port: add_result  input  32  adder sum, combinational from add_a/add_b/add_ao.
REQ-016 SHALL have port: add_carry  input  1  adder bit 32; in subtract mode 1 means A >= B.

Function
REQ-017 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-018 SHALL accept start only in IDLE; start in MUL, DIV or DONE SHALL be ignored with no effect on operands or outputs.
REQ-019 On acceptance SHALL latch rs_val/rt_val, clear the 5-bit iteration counter, go to MUL (op=0) or DIV (op=1).
REQ-020 MUL load: hi=0, lo=rt_val, mcand=rs_val.
REQ-021 MUL iteration: add_a=hi, add_b = lo[0] ? mcand : 0, add_ao=0; then {hi,lo} <= {add_carry, add_result, lo[31:1]}.
REQ-022 DIV load: hi=0, lo=rs_val, divisor=rt_val.
REQ-023 DIV iteration: r_sh={hi[30:0],lo[31]}, msb=hi[31]; add_a=r_sh, add_b=divisor, add_ao=1; if msb or add_carry then hi<=add_result, new quotient bit 1, else hi<=r_sh, bit 0; lo<={lo[30:0],bit}.
REQ-024 Each of MUL/DIV SHALL run exactly 32 iterations, one per cycle; the 32nd iteration transitions to DONE.
REQ-025 DIVU with rt_val=0 SHALL go IDLE->DONE at acceptance: hi=rs_val, lo=32'hFFFFFFFF, div_by_zero=1.
REQ-026 done SHALL be 1 only in DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-027 Latency: done high in the cycle after the 33rd rising edge following acceptance (1 for divide-by-zero).
REQ-028 busy SHALL be 1 in MUL and DIV, 0 in IDLE and DONE.
REQ-029 hi/lo SHALL hold the last result from DONE until the next accepted start.
REQ-030 div_by_zero SHALL clear on the next accepted start.
REQ-031 In IDLE and DONE, add_a=0, add_b=0, add_ao=0.
REQ-032 All arithmetic unsigned, modulo 2^32 per word; no overflow output.

Reset
REQ-033 rst high at a rising edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, regardless of state or start.
REQ-034 Reset mid-operation SHALL discard the operation; no done pulse SHALL follow.
REQ-035 start coincident with rst SHALL be ignored.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done after 33 edges, hi=0xFFFFFFFE, lo=0x00000001, busy high 32 cycles.
REQ-037 DIVU 100 / 7 -> lo=14, hi=2, div_by_zero=0.
REQ-038 DIVU 0xFFFFFFFF / 0x80000001 -> lo=1, hi=0x7FFFFFFE (exercises msb path).
REQ-039 DIVU 0x80000000 / 0 -> done one cycle after accept, hi=0x80000000, lo=0xFFFFFFFF, div_by_zero=1.
REQ-040 MULTU 0x12345678 x 3 with start re-pulsed at iteration 5 -> second start ignored, hi=0, lo=0x369D0368.
REQ-041 rst at iteration 10 of DIVU -> next cycle IDLE, hi=lo=0, no done; following MULTU 6 x 7 -> lo=42, hi=0.
